// File: rtl/seq_pkg.sv
// Shared definitions for the serial bit source and the downstream sequence detector.
// Holds the state encoding, the default word width and a counter-width helper.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // A modulo-1 counter still needs one physical bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N up counter with enable, synchronous clear and a terminal-count flag.
// Clear has priority over enable; the count wraps to zero after N-1.
module mod_counter
    import seq_pkg::*;
#(
    parameter int N = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      en,
    input  logic                      clr,
    output logic [cnt_width(N)-1:0]   count,
    output logic                      tc
);

    localparam int CW = cnt_width(N);

    assign tc = (count == CW'(N - 1));

    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/serial_bit_source.sv
// Parallel-to-serial feeder for the sequence detector: accepts words over valid/ready
// and emits one bit per clock, with optional idle gap cycles after each word.
module serial_bit_source
    import seq_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    input  logic             abort,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bit_cnt;
    logic             bit_tc;
    logic             gap_tc;
    logic             xfer;

    assign xfer = data_valid & data_ready;

    function automatic logic head(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? (v << 1) : (v >> 1);
    endfunction

    // bit_cnt indexes the bit currently shown on serial_out.
    mod_counter #(.N(WIDTH)) u_bit_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (state == SHIFT),
        .clr     (abort | xfer),
        .count   (bit_cnt),
        .tc      (bit_tc)
    );

    generate
        if (GAP_CYCLES > 0) begin : g_gap
            logic [cnt_width(GAP_CYCLES)-1:0] gap_cnt;
            logic                             unused_gap_cnt;

            assign unused_gap_cnt = ^gap_cnt;

            mod_counter #(.N(GAP_CYCLES)) u_gap_cnt (
                .clk     (clk),
                .reset_n (reset_n),
                .en      (state == GAP),
                .clr     (abort),
                .count   (gap_cnt),
                .tc      (gap_tc)
            );
        end else begin : g_no_gap
            assign gap_tc = 1'b0;
        end
    endgenerate

    // NOTE: the shift register is reset along with the control flops so no stale word survives reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            shreg        <= '0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            data_ready   <= 1'b0;
            word_done    <= 1'b0;
            busy         <= 1'b0;
        end else if (abort) begin
            // Abort beats a simultaneous transfer: the accepted word is simply dropped.
            state        <= IDLE;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            data_ready   <= 1'b0;
            word_done    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            word_done <= 1'b0;
            case (state)
                IDLE: begin
                    data_ready <= 1'b1;
                    if (xfer) begin
                        state        <= SHIFT;
                        shreg        <= advance(data_in);
                        serial_out   <= head(data_in);
                        serial_valid <= 1'b1;
                        data_ready   <= 1'b0;
                        busy         <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (!bit_tc) begin
                        serial_out <= head(shreg);
                        shreg      <= advance(shreg);
                        if (bit_cnt == CW'(WIDTH - 2)) begin
                            word_done  <= 1'b1;
                            data_ready <= (GAP_CYCLES == 0);
                        end
                    end else if (GAP_CYCLES == 0 && xfer) begin
                        shreg      <= advance(data_in);
                        serial_out <= head(data_in);
                        data_ready <= 1'b0;
                    end else begin
                        state        <= (GAP_CYCLES == 0) ? IDLE : GAP;
                        serial_out   <= 1'b0;
                        serial_valid <= 1'b0;
                        busy         <= (GAP_CYCLES != 0);
                    end
                end
                GAP: begin
                    if (gap_tc) begin
                        state      <= IDLE;
                        data_ready <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_bit_source.sv
// Scoreboard bench for serial_bit_source: two instances (4-bit MSB-first no gap,
// 8-bit LSB-first with 3 gap cycles) driven with directed and random words.
module tb_serial_bit_source;

    typedef struct packed {
        logic b;
        logic last;
        int   cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] din [2];
    logic        dv  [2];
    logic        ab  [2];
    logic        so  [2];
    logic        sv  [2];
    logic        rdy [2];
    logic        wd  [2];
    logic        bsy [2];

    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    int   last_xfer [2];
    exp_t q0 [$];
    exp_t q1 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_bit_source #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .data_in(din[0][3:0]), .data_valid(dv[0]),
        .data_ready(rdy[0]), .abort(ab[0]), .serial_out(so[0]), .serial_valid(sv[0]),
        .word_done(wd[0]), .busy(bsy[0])
    );

    serial_bit_source #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(3)) dut1 (
        .clk(clk), .reset_n(reset_n), .data_in(din[1][7:0]), .data_valid(dv[1]),
        .data_ready(rdy[1]), .abort(ab[1]), .serial_out(so[1]), .serial_valid(sv[1]),
        .word_done(wd[1]), .busy(bsy[1])
    );

    function automatic int wid(input int i);
        return (i == 0) ? 4 : 8;
    endfunction

    function automatic bit msb_first(input int i);
        return (i == 0);
    endfunction

    task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s dut%0d @cyc %0d: got %0h, want %0h", name, i, cyc, act, exp);
    endtask

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t qpop(input int i);
        if (i == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic exp_t qfront(input int i);
        if (i == 0) return q0[0];
        return q1[0];
    endfunction

    task automatic qpush(input int i, input exp_t e);
        if (i == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic qflush(input int i);
        if (i == 0) q0.delete();
        else q1.delete();
    endtask

    // Reference model: a word accepted at edge k shows bit j during cycle k+j.
    task automatic push_word(input int i, input logic [31:0] d);
        int   k;
        int   w;
        exp_t e;
        k = cyc + 1;
        w = wid(i);
        for (int j = 0; j < w; j++) begin
            e.b    = msb_first(i) ? d[w-1-j] : d[j];
            e.last = (j == w - 1);
            e.cyc  = k + j;
            qpush(i, e);
        end
        last_xfer[i] = k;
    endtask

    // Called at a falling edge; returns at the falling edge after the transfer.
    task automatic send_word(input int i, input logic [31:0] d);
        int guard;
        guard = 0;
        din[i] = d;
        dv[i]  = 1'b1;
        while (rdy[i] !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            total++;
            $display("FAIL ready_timeout dut%0d: data_ready=%b after 200 cycles, want 1", i, rdy[i]);
        end else begin
            push_word(i, d);
        end
        @(negedge clk);
        dv[i] = 1'b0;
    endtask

    task automatic abort_now(input int i, input bit with_xfer);
        int guard;
        guard = 0;
        if (with_xfer) begin
            while (rdy[i] !== 1'b1 && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            din[i] = $urandom;
            dv[i]  = 1'b1;
        end
        ab[i] = 1'b1;
        qflush(i);
        @(negedge clk);
        ab[i] = 1'b0;
        dv[i] = 1'b0;
        check("abort_valid", i, sv[i], 1'b0);
        check("abort_done", i, wd[i], 1'b0);
        check("abort_ready_low", i, rdy[i], 1'b0);
        @(negedge clk);
        check("abort_ready_high", i, rdy[i], 1'b1);
    endtask

    task automatic wait_idle(input int i);
        int guard;
        guard = 0;
        while ((qsize(i) > 0 || bsy[i] === 1'b1) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            total++;
            $display("FAIL idle_timeout dut%0d: busy=%b pending=%0d, want idle", i, bsy[i], qsize(i));
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        for (int i = 0; i < 2; i++) begin
            check("rst_serial_out", i, so[i], 1'b0);
            check("rst_serial_valid", i, sv[i], 1'b0);
            check("rst_data_ready", i, rdy[i], 1'b0);
            check("rst_word_done", i, wd[i], 1'b0);
            check("rst_busy", i, bsy[i], 1'b0);
        end
    endtask

    task automatic monitor(input int i);
        exp_t e;
        if (sv[i] === 1'b1) begin
            if (qsize(i) == 0) begin
                total++;
                $display("FAIL unexpected_bit dut%0d @cyc %0d: serial_valid=1, want 0 (nothing pending)", i, cyc);
            end else begin
                e = qpop(i);
                check("serial_bit", i, so[i], e.b);
                check("word_done", i, wd[i], e.last);
                check("bit_cycle", i, cyc, e.cyc);
                check("busy_shift", i, bsy[i], 1'b1);
            end
        end else begin
            check("idle_out", i, so[i], 1'b0);
            check("idle_done", i, wd[i], 1'b0);
            if (qsize(i) > 0) begin
                e = qfront(i);
                if (e.cyc <= cyc) begin
                    e = qpop(i);
                    total++;
                    $display("FAIL missing_bit dut%0d @cyc %0d: serial_valid=0, want bit %b due at cyc %0d",
                             i, cyc, e.b, e.cyc);
                end
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (reset_n) begin
            for (int i = 0; i < 2; i++) monitor(i);
        end
    end

    initial begin
        int k1;
        int r;
        for (int i = 0; i < 2; i++) begin
            din[i] = '0;
            dv[i]  = 1'b0;
            ab[i]  = 1'b0;
            last_xfer[i] = 0;
        end

        reset_n = 1'b0;
        #12;
        check_reset_outputs();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) check("ready_before_edge", i, rdy[i], 1'b0);
        @(negedge clk);
        for (int i = 0; i < 2; i++) check("ready_after_release", i, rdy[i], 1'b1);

        // Single word, MSB first.
        send_word(0, 32'hD);
        wait_idle(0);

        // Back-to-back stream: second transfer lands on the last-bit edge.
        send_word(0, 32'hD);
        k1 = last_xfer[0];
        send_word(0, 32'h6);
        check("b2b_spacing", 0, last_xfer[0] - k1, 4);
        wait_idle(0);

        // Gap insertion: 8 bits + 3 gap cycles + 1 idle cycle.
        send_word(1, 32'hA5);
        k1 = last_xfer[1];
        send_word(1, 32'hA5);
        check("gap_spacing", 1, last_xfer[1] - k1, 12);
        wait_idle(1);

        // LSB first.
        send_word(1, 32'h01);
        wait_idle(1);

        // Abort during bit 2.
        send_word(1, 32'hFF);
        repeat (2) @(negedge clk);
        abort_now(1, 1'b0);

        // Abort together with a transfer: word accepted and dropped.
        abort_now(0, 1'b1);

        // Asynchronous reset in the middle of a word.
        send_word(0, 32'hB);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs();
        qflush(0);
        qflush(1);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("ready_before_edge2", 0, rdy[0], 1'b0);
        @(posedge clk);
        #2;
        check("ready_after_release2", 0, rdy[0], 1'b1);
        @(negedge clk);

        // Random words with random spacing and occasional aborts.
        for (int i = 0; i < 2; i++) begin
            for (int n = 0; n < 25; n++) begin
                r = $urandom_range(0, 9);
                if (r == 0) begin
                    abort_now(i, 1'b1);
                end else begin
                    send_word(i, $urandom & ((32'd1 << wid(i)) - 1));
                    if (r == 1) begin
                        repeat ($urandom_range(0, wid(i) + 3)) @(negedge clk);
                        abort_now(i, 1'b0);
                    end else begin
                        repeat ($urandom_range(0, 2)) @(negedge clk);
                    end
                end
            end
            wait_idle(i);
            check("drained", i, qsize(i), 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/serial_bit_source.md
# serial_bit_source

Upstream feeder stage for the Moore sequence detector: accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on a serial line. The serial line connects directly to the detector's serial `in` input. The block provides deterministic, gap-controlled bit streams so detector behaviour is reproducible in system tests.

## Interface

**Parameters**
- `WIDTH`, default 8: bits per word, range 2 to 32.
- `MSB_FIRST`, default 1: 1 sends `data_in[WIDTH-1]` first; 0 sends `data_in[0]` first.
- `GAP_CYCLES`, default 0: idle cycles inserted after each word, range 0 to 15.

**Ports**
- `clk`, input, 1: sole clock, rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `data_in`, input, WIDTH: word to serialize; sampled on the handshake.
- `data_valid`, input, 1: producer offers `data_in`.
- `data_ready`, output, 1: registered; block can accept a word this cycle.
- `abort`, input, 1: synchronous; drops the word in flight.
- `serial_out`, output, 1: registered serial bit; feeds the detector's `in`.
- `serial_valid`, output, 1: registered; `serial_out` carries a data bit.
- `word_done`, output, 1: registered one-cycle pulse, coincident with the last bit of a word.
- `busy`, output, 1: registered; high in SHIFT or GAP.

## Operation

**Reset values:** `serial_out`=0, `serial_valid`=0, `data_ready`=0, `word_done`=0, `busy`=0, state=IDLE, counters=0.

**Handshake**
- A transfer occurs at a rising edge where `data_valid` and `data_ready` are both 1.
- `data_in` must be held stable while `data_valid` is high and `data_ready` is low.

**States**
- **IDLE:** `data_ready`=1 from the first edge after reset release. On a transfer, load the shift register, clear the bit counter, go to SHIFT. While idle, `serial_out`=0 and `serial_valid`=0.
- **SHIFT:** present one bit per cycle with `serial_valid`=1. After bit WIDTH-1:
  - if `GAP_CYCLES`=0 and a transfer occurred, stay in SHIFT with the new word;
  - if `GAP_CYCLES`=0 and no transfer, go to IDLE;
  - if `GAP_CYCLES`>0, go to GAP.
- **GAP:** drive `serial_out`=0 and `serial_valid`=0 for `GAP_CYCLES` cycles, then go to IDLE.

**Arithmetic and bit order**
- The bit counter is `$clog2(WIDTH)` bits and wraps at WIDTH-1.
- The shift direction is fixed by `MSB_FIRST`. Vacated bits fill with 0.

**Boundary conditions**
- **Back-to-back words (`GAP_CYCLES`=0):** `data_ready` is registered high during the cycle showing the last bit. A transfer on that edge gives a continuous stream with no bubble.
- **Abort:** `abort`=1 at an edge forces IDLE. `serial_valid`=0 and `word_done`=0 from the next cycle, and the partial word is discarded.
- **Abort with a simultaneous transfer:** abort wins. The word counts as accepted and is dropped.
- **Asynchronous reset mid-word:** all outputs return to their reset values immediately, and no partial word resumes.
- **`data_valid` high during SHIFT before the last bit:** ignored, because `data_ready`=0.

## Timing

- **Latency:** the transfer at edge k puts bit 0 on `serial_out` with `serial_valid`=1 during cycle k+1. The last bit appears during cycle k+WIDTH.
- **Throughput:** one word every WIDTH+`GAP_CYCLES` cycles when the producer is always valid. Add one extra IDLE cycle when `GAP_CYCLES`>0.
- **`word_done`:** high only during cycle k+WIDTH.
- **`data_ready`:** low from the edge after a transfer until re-enabled as described in Operation.
- **All outputs are registered.** There are no combinational input-to-output paths.

## Structure

- **Shared package `seq_pkg`:** holds the state encoding localparams (IDLE=2'd0, SHIFT=2'd1, GAP=2'd2) and the default `WIDTH`. The downstream detector bench uses the same package.
- **One sub-module, `mod_counter`:** a parameterized modulo-N up counter with enable, synchronous clear and a terminal-count flag. It is instantiated twice, once as the bit counter (N=WIDTH) and once as the gap counter (N=`GAP_CYCLES`, omitted by generate when 0).

## Test plan

- **Single word:** `WIDTH`=4, `MSB_FIRST`=1, send 4'b1101 → `serial_out` reads 1,1,0,1 over cycles k+1..k+4, `word_done` is high at k+4, and the attached detector `out` is asserted once.
- **Back-to-back streaming:** `WIDTH`=4, `GAP_CYCLES`=0, send 4'b1101 then 4'b0110 → 8 contiguous valid bits 1,1,0,1,0,1,1,0, and `serial_valid` never drops.
- **Gap insertion:** `GAP_CYCLES`=3, `WIDTH`=8, send 8'hA5 twice → bits 1,0,1,0,0,1,0,1, then 3 cycles with `serial_valid`=0, 1 IDLE cycle, then the second word.
- **LSB-first order:** `MSB_FIRST`=0, send 8'h01 → first bit is 1, followed by seven 0s.
- **Abort mid-word:** abort at bit 2 of 8'hFF → `serial_valid` is 0 from the next cycle, no `word_done`, and `data_ready`=1 one cycle later.
- **Asynchronous reset mid-word:** drop `reset_n` between edges during SHIFT → all outputs go to 0 immediately, and the first edge after release sets `data_ready`=1.
